// File: rtl/deser_pkg.sv
// Shared types and constants for the 1-to-4 deserializer.
package deser_pkg;

    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned SLOT_W    = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

endpackage : deser_pkg

// File: rtl/deser_1x4.sv
// Receive end of a 4:1 serial link: steers slot-ordered bits into a 4-bit word
// and offers the completed word downstream over a valid/ready handshake.
module deser_1x4
    import deser_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 frame_start,
    input  logic                 data_ready,
    output logic [NUM_SLOTS-1:0] data_out,
    output logic                 data_valid,
    output logic [SLOT_W-1:0]    sel,
    output logic                 frame_err,
    output logic                 overflow
);

    // The last slot is written straight into data_out, so only the first
    // three slots need holding storage.
    localparam int unsigned SHIFT_W = NUM_SLOTS - 1;

    state_e               state_q, state_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [SLOT_W-1:0]    sel_q, sel_d;
    logic [NUM_SLOTS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovf_q, ovf_d;

    // Next-state: slot steering, word completion, handshake and error flags.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovf_d   = ovf_q;

        // Pending word leaves when downstream takes it; may be re-set below.
        if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                // Bits without frame_start are outside any frame and dropped.
                if (bit_valid && frame_start) begin
                    shift_d = {SHIFT_W'(0), bit_in} & SHIFT_W'(1) | SHIFT_W'(bit_in);
                    sel_d   = SLOT_W'(1);
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (bit_valid) begin
                    if (frame_start) begin
                        // Early restart: the partial word is abandoned.
                        ferr_d  = 1'b1;
                        shift_d = SHIFT_W'(bit_in);
                        sel_d   = SLOT_W'(1);
                    end else if (sel_q == SLOT_W'(NUM_SLOTS - 1)) begin
                        data_d  = {bit_in, shift_q};
                        valid_d = 1'b1;
                        if (valid_q && !data_ready) begin
                            ovf_d = 1'b1;
                        end
                        sel_d   = '0;
                        state_d = IDLE;
                    end else begin
                        shift_d[sel_q] = bit_in;
                        sel_d          = sel_q + SLOT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign sel        = sel_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;

endmodule : deser_1x4

// File: tb/tb_deser_1x4.sv
// Directed self-checking bench for deser_1x4.
module tb_deser_1x4;

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       frame_start;
    logic       data_ready;
    logic [3:0] data_out;
    logic       data_valid;
    logic [1:0] sel;
    logic       frame_err;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    deser_1x4 dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .data_ready  (data_ready),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .sel         (sel),
        .frame_err   (frame_err),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with a valid bit; outputs are sampled 1 time unit after the edge.
    task automatic send(input logic b, input logic fs);
        bit_valid   = 1'b1;
        bit_in      = b;
        frame_start = fs;
        @(posedge clk);
        #1;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  8'(data_out),   8'h0);
        check({tag, "_valid"}, 8'(data_valid), 8'h0);
        check({tag, "_sel"},   8'(sel),        8'h0);
        check({tag, "_ferr"},  8'(frame_err),  8'h0);
        check({tag, "_ovf"},   8'(overflow),   8'h0);
    endtask

    initial begin
        rst         = 1'b1;
        bit_in      = 1'b0;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        data_ready  = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        check_all_zero("reset");

        // Stray bit in IDLE is dropped.
        send(1'b1, 1'b0);
        check("stray_sel", 8'(sel), 8'h0);
        check("stray_ferr", 8'(frame_err), 8'h0);

        // Single frame 1,0,1,1 -> 4'b1101.
        send(1'b1, 1'b1);
        check("single_sel1", 8'(sel), 8'h1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        check("single_sel3", 8'(sel), 8'h3);
        check("single_novalid", 8'(data_valid), 8'h0);
        send(1'b1, 1'b0);
        check("single_data", 8'(data_out), 8'hD);
        check("single_valid", 8'(data_valid), 8'h1);
        check("single_selwrap", 8'(sel), 8'h0);
        idle(1);
        check("single_consumed", 8'(data_valid), 8'h0);

        // Gapped frame 0,1,(gap),1,0 -> 4'b0110.
        send(1'b0, 1'b1);
        send(1'b1, 1'b0);
        check("gap_sel_before", 8'(sel), 8'h2);
        idle(3);
        check("gap_sel_hold", 8'(sel), 8'h2);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        check("gap_data", 8'(data_out), 8'h6);
        check("gap_valid", 8'(data_valid), 8'h1);
        idle(1);

        // Early restart: 1,1 then restart with 1,0,0,1 -> 4'b1001.
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        check("restart_noerr", 8'(frame_err), 8'h0);
        send(1'b1, 1'b1);
        check("restart_ferr", 8'(frame_err), 8'h1);
        check("restart_sel", 8'(sel), 8'h1);
        send(1'b0, 1'b0);
        check("restart_ferr_pulse", 8'(frame_err), 8'h0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        check("restart_data", 8'(data_out), 8'h9);
        check("restart_valid", 8'(data_valid), 8'h1);
        idle(1);

        // Stall: 4'hA then 4'h5 with data_ready low.
        data_ready = 1'b0;
        send(1'b0, 1'b1);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        check("stall_a_data", 8'(data_out), 8'hA);
        check("stall_a_ovf", 8'(overflow), 8'h0);
        send(1'b1, 1'b1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        check("stall_hold_data", 8'(data_out), 8'hA);
        check("stall_hold_valid", 8'(data_valid), 8'h1);
        send(1'b0, 1'b0);
        check("stall_5_data", 8'(data_out), 8'h5);
        check("stall_5_valid", 8'(data_valid), 8'h1);
        check("stall_ovf", 8'(overflow), 8'h1);
        data_ready = 1'b1;
        idle(1);
        check("stall_drain_valid", 8'(data_valid), 8'h0);
        check("stall_ovf_sticky", 8'(overflow), 8'h1);
        idle(1);
        check("stall_ovf_sticky2", 8'(overflow), 8'h1);

        // Clear overflow, then consume and complete in the same cycle.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst_ovf_clear", 8'(overflow), 8'h0);
        data_ready = 1'b0;
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b0, 1'b0);
        check("simul_first", 8'(data_out), 8'h3);
        send(1'b0, 1'b1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        data_ready = 1'b1;
        send(1'b1, 1'b0);
        check("simul_data", 8'(data_out), 8'hC);
        check("simul_valid", 8'(data_valid), 8'h1);
        check("simul_ovf", 8'(overflow), 8'h0);

        // Reset mid-frame at sel=2 while a word is still shown.
        data_ready = 1'b0;
        send(1'b1, 1'b1);
        send(1'b1, 1'b0);
        check("midrst_sel", 8'(sel), 8'h2);
        rst = 1'b1;
        idle(1);
        check_all_zero("midrst");
        rst = 1'b0;
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_deser_1x4

// File: doc/deser_1x4.md
# deser_1x4

Sequential 1-to-4 deserializer: the receive end of a 4:1 bit-select serializer link. Serial bits arrive one per qualified cycle in slot order 0,1,2,3; the block steers each bit into the matching lane of a 4-bit word. It presents the completed word with a valid/ready handshake to downstream logic. The block sits directly after the serial link, and slot k maps to data_out[k].

## Interface
- Parameters: none. Word width is fixed at 4 and slot width at 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  qualifies bit_in for this cycle.
- frame_start  input  1  marks bit_in as slot 0 of a new word; meaningful only when bit_valid=1.
- data_ready  input  1  downstream accepts data_out this cycle.
- data_out  output  4  assembled word, slot k goes to bit k.
- data_valid  output  1  data_out holds an unconsumed word.
- sel  output  2  slot index the next valid bit will occupy.
- frame_err  output  1  one-cycle pulse when a frame restarts early.
- overflow  output  1  sticky flag; a completed word overwrote an unconsumed one.

## Operation
- Reset values: data_out=4'b0000, data_valid=0, sel=2'b00, frame_err=0, overflow=0, shift register=0, state=IDLE.
- States are IDLE and COLLECT.
- IDLE:
  - bit_valid=1 and frame_start=1: shift[0]<=bit_in, sel<=1, go to COLLECT.
  - bit_valid=1 and frame_start=0: drop the bit, stay in IDLE, sel stays 0, no error flag.
- COLLECT, bit_valid=1 and frame_start=1:
  - Pulse frame_err.
  - Discard the partial word and restart: shift[0]<=bit_in, sel<=1.
- COLLECT, bit_valid=1 and frame_start=0:
  - shift[sel]<=bit_in, sel<=sel+1.
  - When sel==3 this bit completes the word:
    - data_out<={bit_in, shift[2:0]}, data_valid<=1.
    - sel wraps to 0, go to IDLE.
- COLLECT, bit_valid=0: hold state and sel. There is no timeout.
- Output handshake:
  - A word transfers on any cycle with data_valid=1 and data_ready=1; data_valid then falls next cycle unless a new word completes in the same cycle.
  - data_out stays stable while data_valid=1 and no new word completes.
- Simultaneous events:
  - Completion + data_valid=1 + data_ready=1: the old word is consumed, the new word loads, data_valid stays 1, overflow is not set.
  - Completion + data_valid=1 + data_ready=0: the new word overwrites the old one, data_valid stays 1, overflow<=1.
  - overflow clears only on rst.
- Reset mid-frame: the partial word is lost and every output returns to its reset value on the next edge.

## Timing
- Latency: the 4th bit is sampled at edge N, and data_out/data_valid are valid after edge N, so they are visible in cycle N+1.
- Minimum word period is 4 cycles with bit_valid held high. Back-to-back frames need frame_start on every 4th bit.
- frame_err is high for exactly the one cycle after the offending edge.
- sel is registered and always matches the slot of the next accepted bit.
- All outputs are registered. There are no combinational input-to-output paths.

## Structure
- Shared package `deser_pkg`:
  - state typedef with IDLE and COLLECT.
  - NUM_SLOTS=4 and SLOT_W=2.
- Single flat module with no sub-module. The slot counter is 2 bits and inline.

## Test plan
- Reset check: after rst, hold bit_valid=0. Required: data_out=0, data_valid=0, sel=0, frame_err=0, overflow=0.
- Single frame:
  - Stimulus: bits 1,0,1,1 with frame_start on the first bit and data_ready=1.
  - Required: data_out=4'b1101 and data_valid=1 in the cycle after the 4th bit, then data_valid=0 the next cycle.
- Gapped frame:
  - Stimulus: bits 0,1,1,0 with bit_valid low for 3 cycles between bits 2 and 3.
  - Required: sel holds at 2 during the gap; data_out=4'b0110.
- Early restart:
  - Stimulus: after 2 bits, assert frame_start with bit 1, then send 0,0,1.
  - Required: a one-cycle frame_err pulse; data_out=4'b1001 and not a word mixing both frames.
- Stall and overflow:
  - Stimulus: data_ready=0, send words 4'hA then 4'h5 back-to-back.
  - Required: data_out=4'h5, data_valid=1, overflow=1; overflow stays 1 after data_ready rises.
- Simultaneous consume and complete, then reset:
  - Stimulus: data_ready=1 on the completion cycle while a word is pending.
  - Required: the new word loads, data_valid stays 1, overflow stays 0.
  - Then assert rst at sel=2. Required: all outputs are 0 next cycle.
